// File: rtl/jesd207_burst_ctrl.sv
// JESD207 burst controller: sequences ENABLE/TXNRX and the FIFO strobe for one
// burst per start request, with programmable setup/guard spacing.
module jesd207_burst_ctrl #(
   parameter int CNT_WID    = 16,
   parameter int SETUP_CYC  = 3,
   parameter int GUARD_CYC  = 2,
   parameter int PULSE_MODE = 1
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               start,
   input  logic               tx_nrx_req,
   input  logic [CNT_WID-1:0] burst_len,
   input  logic               abort,
   input  logic               fifo_empty,
   input  logic               fifo_full,
   output logic               tx_nrx,
   output logic               jesd_en,
   output logic               rd_en,
   output logic               wr_en,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [CNT_WID-1:0] xfer_cnt
);

   typedef enum logic [2:0] {IDLE, SETUP, TRANS, STOP, GUARD} state_t;

   localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);
   localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYC - 1);

   state_t             state_q, state_d;
   logic [3:0]         tmr_q, tmr_d;
   logic [CNT_WID-1:0] len_q, len_d;
   logic [CNT_WID-1:0] xfer_cnt_q, xfer_cnt_d;
   logic               err_q, err_d;
   logic               tx_nrx_q, tx_nrx_d;
   logic               jesd_en_q, jesd_en_d;
   logic               done_q, done_d;

   logic               blocked;
   logic [CNT_WID-1:0] cnt_inc;

   // The flag that matters depends on the direction latched for this burst.
   assign blocked = tx_nrx_q ? fifo_empty : fifo_full;
   assign cnt_inc = (xfer_cnt_q == '1) ? xfer_cnt_q : xfer_cnt_q + CNT_WID'(1);

   always_comb begin
      state_d    = state_q;
      tmr_d      = tmr_q;
      len_d      = len_q;
      xfer_cnt_d = xfer_cnt_q;
      err_d      = err_q;
      tx_nrx_d   = tx_nrx_q;
      done_d     = 1'b0;
      jesd_en_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               tx_nrx_d   = tx_nrx_req;
               len_d      = burst_len;
               xfer_cnt_d = '0;
               err_d      = 1'b0;
               tmr_d      = '0;
               state_d    = SETUP;
            end
         end
         SETUP: begin
            if (abort) begin
               state_d = STOP;
            end else if (tmr_q == SETUP_LAST) begin
               state_d = TRANS;
            end else begin
               tmr_d = tmr_q + 4'd1;
            end
         end
         TRANS: begin
            // A flag that is already high blocks this cycle's transfer even if
            // it would otherwise have completed the fixed-length burst.
            if (!blocked) begin
               xfer_cnt_d = cnt_inc;
            end
            if (blocked && (len_q != '0)) begin
               err_d = 1'b1;
            end
            if (blocked || abort || ((len_q != '0) && (cnt_inc == len_q))) begin
               state_d = STOP;
            end
         end
         STOP: begin
            tmr_d   = '0;
            state_d = GUARD;
         end
         GUARD: begin
            if (tmr_q == GUARD_LAST) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               tmr_d = tmr_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (PULSE_MODE != 0) begin
         jesd_en_d = ((state_q == IDLE) && (state_d == SETUP)) || (state_d == STOP);
      end else begin
         jesd_en_d = (state_d == SETUP) || (state_d == TRANS);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         tmr_q      <= '0;
         len_q      <= '0;
         xfer_cnt_q <= '0;
         err_q      <= 1'b0;
         tx_nrx_q   <= 1'b1;
         jesd_en_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         len_q      <= len_d;
         xfer_cnt_q <= xfer_cnt_d;
         err_q      <= err_d;
         tx_nrx_q   <= tx_nrx_d;
         jesd_en_q  <= jesd_en_d;
         done_q     <= done_d;
      end
   end

   assign tx_nrx   = tx_nrx_q;
   assign jesd_en  = jesd_en_q;
   assign rd_en    = (state_q == TRANS) && tx_nrx_q;
   assign wr_en    = (state_q == TRANS) && !tx_nrx_q;
   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign err      = err_q;
   assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_jesd207_burst_ctrl.sv
// Bench for jesd207_burst_ctrl: pulse- and level-mode instances share stimulus
// and are checked every cycle against a burst-timeline model.
module tb_jesd207_burst_ctrl;

   localparam int SETUP_CYC = 3;
   localparam int GUARD_CYC = 2;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        start = 1'b0;
   logic        tx_nrx_req = 1'b1;
   logic [15:0] burst_len = '0;
   logic        abort = 1'b0;
   logic        fifo_empty = 1'b0;
   logic        fifo_full = 1'b0;

   logic        p_tx_nrx, p_jesd_en, p_rd_en, p_wr_en, p_busy, p_done, p_err;
   logic [15:0] p_xfer_cnt;
   logic        l_tx_nrx, l_jesd_en, l_rd_en, l_wr_en, l_busy, l_done, l_err;
   logic [15:0] l_xfer_cnt;

   jesd207_burst_ctrl #(.CNT_WID(16), .SETUP_CYC(SETUP_CYC), .GUARD_CYC(GUARD_CYC), .PULSE_MODE(1)) u_pulse (
      .clk(clk), .rstn(rstn), .start(start), .tx_nrx_req(tx_nrx_req), .burst_len(burst_len),
      .abort(abort), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
      .tx_nrx(p_tx_nrx), .jesd_en(p_jesd_en), .rd_en(p_rd_en), .wr_en(p_wr_en),
      .busy(p_busy), .done(p_done), .err(p_err), .xfer_cnt(p_xfer_cnt));

   jesd207_burst_ctrl #(.CNT_WID(16), .SETUP_CYC(SETUP_CYC), .GUARD_CYC(GUARD_CYC), .PULSE_MODE(0)) u_level (
      .clk(clk), .rstn(rstn), .start(start), .tx_nrx_req(tx_nrx_req), .burst_len(burst_len),
      .abort(abort), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
      .tx_nrx(l_tx_nrx), .jesd_en(l_jesd_en), .rd_en(l_rd_en), .wr_en(l_wr_en),
      .busy(l_busy), .done(l_done), .err(l_err), .xfer_cnt(l_xfer_cnt));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   // Model state: the burst is described by its accept edge and its stop edge.
   int          cyc = 0;
   int          m_e0 = 0;
   int          m_stop = -1;
   bit          m_active = 1'b0;
   bit          m_tx = 1'b1;
   bit          m_err = 1'b0;
   bit          m_done = 1'b0;
   logic [15:0] m_cnt = '0;
   logic [15:0] m_len = '0;

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
      end
   endtask

   always @(posedge clk) begin
      bit blk, e_trans, e_jp, e_jl;
      cyc++;
      if (!rstn) begin
         m_active = 1'b0;
         m_tx     = 1'b1;
         m_err    = 1'b0;
         m_done   = 1'b0;
         m_cnt    = '0;
         m_stop   = -1;
      end else begin
         m_done = 1'b0;
         if (!m_active) begin
            if (start) begin
               m_active = 1'b1;
               m_e0     = cyc;
               m_stop   = -1;
               m_tx     = tx_nrx_req;
               m_len    = burst_len;
               m_cnt    = '0;
               m_err    = 1'b0;
            end
         end else if (m_stop < 0) begin
            if (cyc <= m_e0 + SETUP_CYC) begin
               if (abort) m_stop = cyc;
            end else begin
               blk = m_tx ? fifo_empty : fifo_full;
               if (!blk && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
               if (blk && m_len != 0) m_err = 1'b1;
               if (blk || abort || (m_len != 0 && !blk && m_cnt == m_len)) m_stop = cyc;
            end
         end else if (cyc == m_stop + 1 + GUARD_CYC) begin
            m_active = 1'b0;
            m_done   = 1'b1;
         end

         e_trans = m_active && (m_stop < 0) && (cyc >= m_e0 + SETUP_CYC);
         e_jp    = m_active && ((cyc == m_e0) || (cyc == m_stop));
         e_jl    = m_active && (m_stop < 0);

         #1;
         if (rstn) begin
            checkOutput("p_tx_nrx", 16'(p_tx_nrx), 16'(m_tx));
            checkOutput("p_jesd_en", 16'(p_jesd_en), 16'(e_jp));
            checkOutput("p_rd_en", 16'(p_rd_en), 16'(e_trans && m_tx));
            checkOutput("p_wr_en", 16'(p_wr_en), 16'(e_trans && !m_tx));
            checkOutput("p_busy", 16'(p_busy), 16'(m_active));
            checkOutput("p_done", 16'(p_done), 16'(m_done));
            checkOutput("p_err", 16'(p_err), 16'(m_err));
            checkOutput("p_xfer_cnt", p_xfer_cnt, m_cnt);
            checkOutput("l_tx_nrx", 16'(l_tx_nrx), 16'(m_tx));
            checkOutput("l_jesd_en", 16'(l_jesd_en), 16'(e_jl));
            checkOutput("l_rd_en", 16'(l_rd_en), 16'(e_trans && m_tx));
            checkOutput("l_wr_en", 16'(l_wr_en), 16'(e_trans && !m_tx));
            checkOutput("l_busy", 16'(l_busy), 16'(m_active));
            checkOutput("l_done", 16'(l_done), 16'(m_done));
            checkOutput("l_err", 16'(l_err), 16'(m_err));
            checkOutput("l_xfer_cnt", l_xfer_cnt, m_cnt);
         end
      end
   end

   // Runs one burst; k counts edges since the accepting edge, observed at negedges.
   task automatic applyStimulus(input logic tx, input logic [15:0] len, input int flag_after,
                                input int abort_k, input int busy_start_k, input bit rnd,
                                output int str_cnt, output int first_k, output int jp_cnt,
                                output int jl_cnt, output int done_k);
      int k;
      str_cnt = 0; first_k = -1; jp_cnt = 0; jl_cnt = 0; done_k = -1;
      @(negedge clk);
      start = 1'b1; tx_nrx_req = tx; burst_len = len;
      abort = 1'b0; fifo_empty = 1'b0; fifo_full = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (k = 0; k < 400; k++) begin
         if (p_rd_en || p_wr_en) begin
            str_cnt++;
            if (first_k < 0) first_k = k;
         end
         if (p_jesd_en) jp_cnt++;
         if (l_jesd_en) jl_cnt++;
         if (p_done) begin
            done_k = k;
            start = 1'b0; abort = 1'b0; fifo_empty = 1'b0; fifo_full = 1'b0;
            break;
         end
         if (rnd) begin
            abort      = ($urandom_range(0, 29) == 0);
            fifo_empty = ($urandom_range(0, 9) == 0);
            fifo_full  = ($urandom_range(0, 9) == 0);
            start      = ($urandom_range(0, 5) == 0);
            tx_nrx_req = 1'($urandom_range(0, 1));
            burst_len  = 16'($urandom_range(0, 12));
         end else begin
            abort      = (k == abort_k);
            start      = (k == busy_start_k);
            tx_nrx_req = (k == busy_start_k) ? ~tx : tx;
            fifo_empty = (flag_after >= 0) && tx && (int'(p_xfer_cnt) >= flag_after);
            fifo_full  = (flag_after >= 0) && !tx && (int'(p_xfer_cnt) >= flag_after);
         end
         @(negedge clk);
      end
      if (done_k < 0) begin
         checkOutput("burst_timeout", 16'(0), 16'(1));
         start = 1'b0; abort = 1'b0; fifo_empty = 1'b0; fifo_full = 1'b0;
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_tx_nrx"}, 16'(p_tx_nrx), 16'(1));
      checkOutput({tag, "_jesd_en"}, 16'(p_jesd_en), 16'(0));
      checkOutput({tag, "_rd_en"}, 16'(p_rd_en), 16'(0));
      checkOutput({tag, "_wr_en"}, 16'(p_wr_en), 16'(0));
      checkOutput({tag, "_busy"}, 16'(p_busy), 16'(0));
      checkOutput({tag, "_done"}, 16'(p_done), 16'(0));
      checkOutput({tag, "_err"}, 16'(p_err), 16'(0));
      checkOutput({tag, "_xfer"}, p_xfer_cnt, 16'd0);
      checkOutput({tag, "_l_jesd_en"}, 16'(l_jesd_en), 16'(0));
      checkOutput({tag, "_l_busy"}, 16'(l_busy), 16'(0));
   endtask

   initial begin
      int sc, fk, jp, jl, dk;

      #2 rstn = 1'b0;
      #1 checkResetValues("rst0");
      @(negedge clk);
      rstn = 1'b1;

      $display("[TB] pulse-mode TX, fixed length 8");
      applyStimulus(1'b1, 16'd8, -1, -1, -1, 1'b0, sc, fk, jp, jl, dk);
      checkOutput("t1_strobes", 16'(sc), 16'd8);
      checkOutput("t1_first_strobe", 16'(fk), 16'd3);
      checkOutput("t1_pulse_jesd", 16'(jp), 16'd2);
      checkOutput("t1_level_jesd", 16'(jl), 16'd11);
      checkOutput("t1_done_k", 16'(dk), 16'd14);
      checkOutput("t1_xfer", p_xfer_cnt, 16'd8);
      checkOutput("t1_err", 16'(p_err), 16'd0);

      $display("[TB] RX until full after 5 writes");
      applyStimulus(1'b0, 16'd0, 5, -1, -1, 1'b0, sc, fk, jp, jl, dk);
      checkOutput("t2_strobes", 16'(sc), 16'd6);
      checkOutput("t2_level_jesd", 16'(jl), 16'd9);
      checkOutput("t2_done_k", 16'(dk), 16'd12);
      checkOutput("t2_xfer", l_xfer_cnt, 16'd5);
      checkOutput("t2_err", 16'(l_err), 16'd0);
      checkOutput("t2_tx_nrx", 16'(p_tx_nrx), 16'd0);

      $display("[TB] TX length 10, empty after 4 reads");
      applyStimulus(1'b1, 16'd10, 4, -1, -1, 1'b0, sc, fk, jp, jl, dk);
      checkOutput("t3_xfer", p_xfer_cnt, 16'd4);
      checkOutput("t3_err", 16'(p_err), 16'd1);
      checkOutput("t3_done_k", 16'(dk), 16'd11);

      $display("[TB] abort during setup");
      applyStimulus(1'b1, 16'd5, -1, 0, -1, 1'b0, sc, fk, jp, jl, dk);
      checkOutput("t4_strobes", 16'(sc), 16'd0);
      checkOutput("t4_pulse_jesd", 16'(jp), 16'd2);
      checkOutput("t4_done_k", 16'(dk), 16'd4);
      checkOutput("t4_xfer", p_xfer_cnt, 16'd0);
      checkOutput("t4_err_cleared", 16'(p_err), 16'd0);

      $display("[TB] abort on final transfer, start while busy");
      applyStimulus(1'b0, 16'd6, -1, 8, 2, 1'b0, sc, fk, jp, jl, dk);
      checkOutput("t5_xfer", p_xfer_cnt, 16'd6);
      checkOutput("t5_err", 16'(p_err), 16'd0);
      checkOutput("t5_tx_nrx", 16'(p_tx_nrx), 16'd0);
      checkOutput("t5_done_k", 16'(dk), 16'd12);

      $display("[TB] async reset during transfer");
      @(negedge clk);
      start = 1'b1; tx_nrx_req = 1'b0; burst_len = 16'd20;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      #2 rstn = 1'b0;
      #1 checkResetValues("rst1");
      @(negedge clk);
      rstn = 1'b1;
      applyStimulus(1'b1, 16'd8, -1, -1, -1, 1'b0, sc, fk, jp, jl, dk);
      checkOutput("t6_strobes", 16'(sc), 16'd8);
      checkOutput("t6_done_k", 16'(dk), 16'd14);
      checkOutput("t6_xfer", p_xfer_cnt, 16'd8);

      $display("[TB] randomized bursts");
      for (int b = 0; b < 40; b++) begin
         applyStimulus(1'($urandom_range(0, 1)), 16'($urandom_range(0, 12)), -1, -1, -1, 1'b1,
                       sc, fk, jp, jl, dk);
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
